// File: rtl/kamus_l1d_responder.sv
// L1 data-memory responder: one request at a time, LATENCY wait states, then a
// held response. The word SRAM is written only on the access edge, so a reset during the wait discards the store.
module kamus_l1d_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]    cnt;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          we_q, err_q;
  logic [3:0]    be_q;
  logic          accept, access;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          rng_err, be_err, acc_err;
  logic [31:0]   mem [DEPTH_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE) && !rst_i;
    rsp_valid_o = (state == RESP);
    access      = (state == WAIT) && (cnt == 4'd0);
  end

  assign accept      = req_valid_i && req_ready_o;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Access checks run on the latched request so they are stable through WAIT.
  assign off     = addr_q - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign rng_err = |off[31:AW+2];

  always_comb begin
    case (be_q)
      4'b0001: be_err = (off[1:0] != 2'd0);
      4'b0010: be_err = (off[1:0] != 2'd1);
      4'b0100: be_err = (off[1:0] != 2'd2);
      4'b1000: be_err = (off[1:0] != 2'd3);
      4'b0011: be_err = off[1];
      4'b1100: be_err = !off[1];
      4'b1111: be_err = (off[1:0] != 2'd0);
      default: be_err = 1'b1;
    endcase
  end

  assign acc_err = rng_err || be_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= LAT4;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        be_q    <= req_be_i;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || we_q) ? 32'd0 : mem[idx];
      end
    end
  end

  // SRAM array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (access && we_q && !acc_err)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_kamus_l1d_responder.sv
// Bench for kamus_l1d_responder: three builds (LATENCY 1, 0, 15) share one clock
// and reset; directed scenarios plus random traffic against a word-map model.
module tb_kamus_l1d_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       req_valid, req_we, rsp_ready;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [2:0][3:0]  req_be;
  wire  [2:0]       req_ready, rsp_valid, rsp_err;
  wire  [2:0][31:0] rsp_rdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    kamus_l1d_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (g == 0 ? 1 : (g == 1 ? 0 : 15)),
      .BASE_ADDR  (32'h0)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_addr_i (req_addr[g]),
      .req_we_i   (req_we[g]),
      .req_be_i   (req_be[g]),
      .req_wdata_i(req_wdata[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .rsp_err_o  (rsp_err[g])
    );
  end

  int n_cmp = 0, n_mis = 0;
  int lat_of [3] = '{1, 0, 15};
  logic [31:0] ref_mem [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected error from the address/lane rules, written with plain arithmetic.
  function automatic bit exp_err(input logic [31:0] addr, input logic [3:0] be);
    int unsigned off = addr;
    if (off >= 4096) return 1;
    case (be)
      4'b0001: return (off % 4) != 0;
      4'b0010: return (off % 4) != 1;
      4'b0100: return (off % 4) != 2;
      4'b1000: return (off % 4) != 3;
      4'b0011: return ((off / 2) % 2) != 0;
      4'b1100: return ((off / 2) % 2) != 1;
      4'b1111: return (off % 4) != 0;
      default: return 1;
    endcase
  endfunction

  // One full transaction on instance k, with optional response stall and
  // junk request activity during the wait; checks against the model.
  task automatic txn(input int k, input bit we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input int stall, input bit junk);
    int n;
    int key;
    bit e;
    logic [31:0] rd, exp_rd, w;
    logic er;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_to", 32'(n < 50), 32'd1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_be[k] = be; req_wdata[k] = wdata;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!rsp_valid[k]) begin
        chk("ready_in_wait", 32'(req_ready[k]), 32'd0);
        if (junk) begin
          req_valid[k] = 1'($urandom); req_addr[k] = $urandom; req_we[k] = 1'($urandom);
          req_be[k] = 4'($urandom); req_wdata[k] = $urandom;
        end
      end
    end while (!rsp_valid[k] && n < 40);
    req_valid[k] = 1'b0;
    if (!rsp_valid[k]) begin
      chk("rsp_valid_to", 32'd0, 32'd1);
      return;
    end
    chk("latency", n, lat_of[k] + 1);
    rd = rsp_rdata[k]; er = rsp_err[k];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
      chk("stall_rdata", rsp_rdata[k], rd);
      chk("stall_err", 32'(rsp_err[k]), 32'(er));
      chk("stall_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(rsp_valid[k]), 32'd0);
    chk("idle_ready", 32'(req_ready[k]), 32'd1);

    e = exp_err(addr, be);
    key = k * 4096 + int'(addr >> 2);
    chk("err", 32'(er), 32'(e));
    if (e || we) begin
      chk("rdata", rd, 32'd0);
    end else if (ref_mem.exists(key)) begin
      exp_rd = ref_mem[key];
      chk("rdata", rd, exp_rd);
    end
    if (we && !e) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[key] = w;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    int k, m;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'd0);
      chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rdata", rsp_rdata[i], 32'd0);
      chk("rst_err", 32'(rsp_err[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h7);

    // basic word store/load, then byte and halfword merges
    txn(0, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 0);
    txn(0, 0, 32'h10, 4'b1111, 32'h0, 0, 0);
    chk("t1_word", ref_mem[4], 32'hDEADBEEF);
    txn(0, 1, 32'h10, 4'b0001, 32'h000000AA, 0, 0);
    txn(0, 0, 32'h10, 4'b1111, 32'h0, 0, 0);
    txn(0, 1, 32'h12, 4'b1100, 32'h55550000, 0, 0);
    txn(0, 0, 32'h10, 4'b1111, 32'h0, 0, 0);
    chk("t2_word", ref_mem[4], 32'h5555BEAA);

    // range and alignment errors leave memory untouched
    txn(0, 0, 32'd4096, 4'b1111, 32'h0, 0, 0);
    txn(0, 1, 32'h11, 4'b1111, 32'hFFFFFFFF, 0, 0);
    txn(0, 0, 32'h10, 4'b1111, 32'h0, 0, 0);

    // response backpressure
    txn(0, 0, 32'h10, 4'b1111, 32'h0, 5, 0);

    // latency 0 and 15 builds, with junk request activity during the wait
    txn(1, 1, 32'h8, 4'b1111, 32'hCAFEF00D, 0, 1);
    txn(1, 0, 32'h8, 4'b1111, 32'h0, 2, 1);
    txn(2, 1, 32'h8, 4'b1111, 32'h0BADF00D, 0, 1);
    txn(2, 0, 32'h8, 4'b1111, 32'h0, 3, 1);

    // reset during the wait of a store: store is dropped, outputs clear at once
    txn(0, 1, 32'h20, 4'b1111, 32'h0, 0, 0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_be[0] = 4'b1111; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready[0]), 32'd0);
    chk("midrst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rdata", rsp_rdata[0], 32'd0);
    chk("midrst_err", 32'(rsp_err[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(0, 0, 32'h20, 4'b1111, 32'h0, 0, 0);
    chk("t6_word", ref_mem[8], 32'h0);

    // seed known contents, then random traffic
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 16; w++)
        txn(i, 1, 32'(w * 4), 4'b1111, $urandom, 0, 0);
    for (int r = 0; r < 80; r++) begin
      k = $urandom_range(0, 2);
      m = $urandom_range(0, 3);
      if (m == 0) begin
        a = $urandom_range(0, 63); b = 4'($urandom);
      end else if (m == 1) begin
        a = 32'($urandom_range(0, 15) * 4); b = 4'b1111;
      end else if (m == 2) begin
        a = $urandom_range(0, 63);
        b = 4'($urandom_range(0, 1) ? (4'b0001 << (a % 4)) : ((a % 4) < 2 ? 4'b0011 : 4'b1100));
      end else begin
        a = 32'd4096 + $urandom_range(0, 255); b = 4'b1111;
      end
      txn(k, 1'($urandom), a, b, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
